// File: rtl/mem_pattern_tester.sv
// Memory pattern tester: runs write/read sweeps through a DRAM controller and checks read-back data.
// Define MEM_TESTER_ERRLOG_EN to add first-mismatch capture ports (err_exp, err_got, err_idx).
module mem_pattern_tester #(
    parameter int DATA_W   = 16,
    parameter int LFSR_LEN = 17,
    parameter int LFSR_TAP = 14,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic [1:0]        mode,
    output logic              ctl_start,
    output logic              ctl_rnw,
    input  logic              ctl_stop,
    input  logic              ctl_ready,
    input  logic [DATA_W-1:0] ctl_rdat,
    output logic [DATA_W-1:0] ctl_wdat,
    output logic              busy,
    output logic [CNT_W-1:0]  pass_counter,
    output logic [CNT_W-1:0]  fail_counter,
    output logic [CNT_W-1:0]  err_words
`ifdef MEM_TESTER_ERRLOG_EN
    ,
    output logic [DATA_W-1:0] err_exp,
    output logic [DATA_W-1:0] err_got,
    output logic [CNT_W-1:0]  err_idx
`endif
);

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_WAIT_IDLE, S_BEGIN_WRITE, S_WRITE, S_BEGIN_READ, S_READ, S_END_PASS
    } state_t;

    localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0] WALK_SEED = {{(DATA_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0] CHK_SEED  = {(DATA_W/2){2'b01}};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    state_t                state_q, state_d;
    logic [1:0]            mode_q, mode_d;
    logic [LFSR_LEN-1:0]   lfsr_q, lfsr_d, sv_lfsr_q, sv_lfsr_d;
    logic [DATA_W-1:0]     walk_q, walk_d, sv_walk_q, sv_walk_d;
    logic [DATA_W-1:0]     chk_q, chk_d, sv_chk_q, sv_chk_d;
    logic                  start_q, start_d, rnw_q, rnw_d;
    logic [CNT_W-1:0]      pass_q, pass_d, fail_q, fail_d;
    logic [CNT_W-1:0]      errw_q, errw_d, errcnt_q, errcnt_d;
    logic                  was_err_q, was_err_d, mism_q, mism_d;
    logic                  advance;
    logic [DATA_W-1:0]     pat_word;

    always_comb begin
        case (mode_q)
            2'd0:    pat_word = lfsr_q[DATA_W-1:0];
            2'd1:    pat_word = ~lfsr_q[DATA_W-1:0];
            2'd2:    pat_word = walk_q;
            default: pat_word = chk_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        lfsr_d    = lfsr_q;
        walk_d    = walk_q;
        chk_d     = chk_q;
        sv_lfsr_d = sv_lfsr_q;
        sv_walk_d = sv_walk_q;
        sv_chk_d  = sv_chk_q;
        start_d   = 1'b0;
        rnw_d     = rnw_q;
        pass_d    = pass_q;
        fail_d    = fail_q;
        errw_d    = errw_q;
        errcnt_d  = errcnt_q;
        was_err_d = was_err_q;
        mism_d    = 1'b0;
        advance   = 1'b0;

        case (state_q)
            S_IDLE:        if (run) state_d = S_INIT;
            S_INIT: begin
                state_d = S_WAIT_IDLE;
                lfsr_d  = '1;
                walk_d  = WALK_SEED;
                chk_d   = CHK_SEED;
            end
            S_WAIT_IDLE:   if (ctl_stop) state_d = S_BEGIN_WRITE;
            S_BEGIN_WRITE: if (!ctl_stop) state_d = S_WRITE;
            S_WRITE: begin
                advance = ctl_ready;
                if (ctl_stop) state_d = S_BEGIN_READ;
            end
            S_BEGIN_READ:  if (!ctl_stop) state_d = S_READ;
            S_READ: begin
                advance = ctl_ready;
                mism_d  = ctl_ready && (ctl_rdat != pat_word);
                if (ctl_stop) state_d = S_END_PASS;
            end
            S_END_PASS:    state_d = run ? S_BEGIN_WRITE : S_IDLE;
            default:       state_d = S_IDLE;
        endcase

        if (advance) begin
            lfsr_d = {lfsr_q[LFSR_LEN-2:0], lfsr_q[LFSR_LEN-1] ^ lfsr_q[LFSR_TAP-1]};
            walk_d = {walk_q[DATA_W-2:0], walk_q[DATA_W-1]};
            chk_d  = ~chk_q;
        end

        // Entry actions; the restore on BEGIN_READ must win over a same-cycle advance.
        if (state_d != state_q) begin
            case (state_d)
                S_INIT: begin
                    start_d = 1'b1;
                    rnw_d   = 1'b1;
                end
                S_BEGIN_WRITE: begin
                    start_d   = 1'b1;
                    rnw_d     = 1'b0;
                    mode_d    = mode;
                    sv_lfsr_d = lfsr_q;
                    sv_walk_d = walk_q;
                    sv_chk_d  = chk_q;
                end
                S_BEGIN_READ: begin
                    start_d = 1'b1;
                    rnw_d   = 1'b1;
                    lfsr_d  = sv_lfsr_q;
                    walk_d  = sv_walk_q;
                    chk_d   = sv_chk_q;
                end
                default: ;
            endcase
        end

        // The compare result of the final read word lands during END_PASS, so fold it in here.
        if (state_q == S_END_PASS) begin
            if (was_err_q || mism_q) fail_d = sat_inc(fail_q);
            else                     pass_d = sat_inc(pass_q);
            errw_d    = mism_q ? sat_inc(errcnt_q) : errcnt_q;
            errcnt_d  = '0;
            was_err_d = 1'b0;
        end else if (mism_q) begin
            errcnt_d  = sat_inc(errcnt_q);
            was_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            mode_q    <= 2'd0;
            lfsr_q    <= '1;
            walk_q    <= '1;
            chk_q     <= '1;
            sv_lfsr_q <= '1;
            sv_walk_q <= '1;
            sv_chk_q  <= '1;
            start_q   <= 1'b0;
            rnw_q     <= 1'b1;
            pass_q    <= '0;
            fail_q    <= '0;
            errw_q    <= '0;
            errcnt_q  <= '0;
            was_err_q <= 1'b0;
            mism_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            lfsr_q    <= lfsr_d;
            walk_q    <= walk_d;
            chk_q     <= chk_d;
            sv_lfsr_q <= sv_lfsr_d;
            sv_walk_q <= sv_walk_d;
            sv_chk_q  <= sv_chk_d;
            start_q   <= start_d;
            rnw_q     <= rnw_d;
            pass_q    <= pass_d;
            fail_q    <= fail_d;
            errw_q    <= errw_d;
            errcnt_q  <= errcnt_d;
            was_err_q <= was_err_d;
            mism_q    <= mism_d;
        end
    end

    assign ctl_start    = start_q;
    assign ctl_rnw      = rnw_q;
    assign ctl_wdat     = pat_word;
    assign busy         = (state_q != S_IDLE);
    assign pass_counter = pass_q;
    assign fail_counter = fail_q;
    assign err_words    = errw_q;

`ifdef MEM_TESTER_ERRLOG_EN
    logic [DATA_W-1:0] cmp_exp_q, cmp_got_q, err_exp_q, err_got_q;
    logic [CNT_W-1:0]  rd_idx_q, cmp_idx_q, err_idx_q;

    // Capture pipeline mirrors mism_q so the logged word lines up with the counted mismatch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_exp_q <= '0;
            cmp_got_q <= '0;
            cmp_idx_q <= '0;
            rd_idx_q  <= '0;
            err_exp_q <= '0;
            err_got_q <= '0;
            err_idx_q <= '0;
        end else begin
            if (state_q == S_BEGIN_READ) begin
                rd_idx_q <= '0;
            end else if (state_q == S_READ && ctl_ready) begin
                cmp_exp_q <= pat_word;
                cmp_got_q <= ctl_rdat;
                cmp_idx_q <= rd_idx_q;
                rd_idx_q  <= rd_idx_q + CNT_ONE;
            end
            if (state_q == S_BEGIN_WRITE) begin
                err_exp_q <= '0;
                err_got_q <= '0;
                err_idx_q <= '0;
            end else if (mism_q && !was_err_q) begin
                err_exp_q <= cmp_exp_q;
                err_got_q <= cmp_got_q;
                err_idx_q <= cmp_idx_q;
            end
        end
    end

    assign err_exp = err_exp_q;
    assign err_got = err_got_q;
    assign err_idx = err_idx_q;
`else
    // Default build: no first-mismatch capture registers.
`endif

endmodule

// File: tb/tb_mem_pattern_tester.sv
// Bench for mem_pattern_tester: a DRAM controller/memory model plus a pattern model that predicts
// every written word and the pass/fail/err_words outcome of each pass.
module tb_mem_pattern_tester;
    localparam int DW   = 16;
    localparam int LL   = 17;
    localparam int LT   = 14;
    localparam int CW   = 4;
    localparam int MAXW = 1024;
    localparam int CMAX = 15;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          run = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic          ctl_start, ctl_rnw;
    logic          ctl_stop = 1'b1;
    logic          ctl_ready = 1'b0;
    logic [DW-1:0] ctl_rdat = '0;
    logic [DW-1:0] ctl_wdat;
    logic          busy;
    logic [CW-1:0] pass_counter, fail_counter, err_words;
`ifdef MEM_TESTER_ERRLOG_EN
    logic [DW-1:0] err_exp, err_got;
    logic [CW-1:0] err_idx;
`endif

    mem_pattern_tester #(.DATA_W(DW), .LFSR_LEN(LL), .LFSR_TAP(LT), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .mode(mode),
        .ctl_start(ctl_start), .ctl_rnw(ctl_rnw), .ctl_stop(ctl_stop), .ctl_ready(ctl_ready),
        .ctl_rdat(ctl_rdat), .ctl_wdat(ctl_wdat), .busy(busy),
        .pass_counter(pass_counter), .fail_counter(fail_counter), .err_words(err_words)
`ifdef MEM_TESTER_ERRLOG_EN
        , .err_exp(err_exp), .err_got(err_got), .err_idx(err_idx)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
        end
    endtask

    // Scenario controls
    int n_words = 8, flip_addr = -1, fast_stop = 0, cur_mode = 0;
    // Controller / model state
    logic [DW-1:0] mem [MAXW];
    logic [DW-1:0] wr_log [32];
    logic [LL-1:0] m_lfsr;
    int  m_k, words_done, verify_starts, wr_pass, errs_this;
    int  exp_pass, exp_fail, exp_errw, m_first_idx;
    logic [DW-1:0] m_first_exp;
    bit  active, sw_rnw, sw_verify, prev_write, start_prev;

    function automatic logic [LL-1:0] lfsr_next(input logic [LL-1:0] s);
        return {s[LL-2:0], s[LL-1] ^ s[LT-1]};
    endfunction

    // The pattern word k positions into the sequence that restarted at the last dummy sweep.
    function automatic logic [DW-1:0] model_word(input int m, input int k, input logic [LL-1:0] lf);
        logic [DW-1:0] one;
        one = 1;
        case (m)
            0:       return lf[DW-1:0];
            1:       return ~lf[DW-1:0];
            2:       return one << (k % DW);
            default: return (k % 2 == 0) ? 16'h5555 : 16'hAAAA;
        endcase
    endfunction

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    task automatic end_pass_model();
        if (errs_this == 0) exp_pass = sat(exp_pass + 1);
        else                exp_fail = sat(exp_fail + 1);
        exp_errw = sat(errs_this);
    endtask

    // Controller model and per-cycle compare: drives inputs and checks outputs on the falling edge.
    initial begin
        logic [DW-1:0] mask, w;
        forever begin
            @(negedge clk);
            ctl_ready = 1'b0;
            if (!rst_n) begin
                ctl_stop = 1'b1; active = 0; prev_write = 0; start_prev = 0;
                exp_pass = 0; exp_fail = 0; exp_errw = 0; verify_starts = 0; wr_pass = 0;
                m_k = 0; m_lfsr = '1; m_first_idx = -1;
            end else if (ctl_start) begin
                check("start_one_cycle", start_prev, 0);
                start_prev = 1; active = 1; words_done = 0; sw_rnw = ctl_rnw; sw_verify = 0;
                ctl_stop = 1'b0;
                if (!sw_rnw) begin
                    check("pass_counter_at_pass", pass_counter, exp_pass);
                    check("fail_counter_at_pass", fail_counter, exp_fail);
                    check("err_words_at_pass", err_words, exp_errw);
                    prev_write = 1; wr_pass++;
                end else if (prev_write) begin
                    sw_verify = 1; verify_starts++; errs_this = 0; prev_write = 0; m_first_idx = -1;
                end else begin
                    m_k = 0; m_lfsr = '1; wr_pass = 0;
                end
            end else begin
                start_prev = 0;
                if (active) begin
                    check("rnw_stable", ctl_rnw, sw_rnw);
                    if (words_done >= n_words) begin
                        ctl_stop = 1'b1; active = 0;
                        if (sw_verify) end_pass_model();
                    end else if ($urandom_range(0, 3) != 0) begin
                        ctl_ready = 1'b1;
                        if (!sw_rnw) begin
                            w = model_word(cur_mode, m_k, m_lfsr);
                            check("wdat", ctl_wdat, w);
                            mem[words_done] = ctl_wdat;
                            if (wr_pass == 1 && words_done < 32) wr_log[words_done] = ctl_wdat;
                            m_lfsr = lfsr_next(m_lfsr); m_k++;
                        end else begin
                            mask = (flip_addr == -2 || flip_addr == words_done) ? 16'h0001 : 16'h0000;
                            ctl_rdat = mem[words_done] ^ mask;
                            if (sw_verify && mask != 0) begin
                                if (errs_this == 0) begin
                                    m_first_idx = words_done; m_first_exp = mem[words_done];
                                end
                                errs_this++;
                            end
                        end
                        words_done++;
                        if (fast_stop != 0 && words_done == n_words) begin
                            ctl_stop = 1'b1; active = 0;
                            if (sw_verify) end_pass_model();
                        end
                    end
                end
            end
        end
    end

    task automatic do_reset();
        run = 1'b0;
        @(negedge clk); #2 rst_n = 1'b0;
        @(negedge clk); #1;
        check("rst_busy", busy, 0);
        check("rst_start", ctl_start, 0);
        check("rst_rnw", ctl_rnw, 1);
        check("rst_pass", pass_counter, 0);
        check("rst_fail", fail_counter, 0);
        check("rst_errw", err_words, 0);
        @(negedge clk); #2 rst_n = 1'b1;
    endtask

    task automatic scenario(input int m, input int n, input int passes, input int fa, input int fs,
                            input int e_pass, input int e_fail, input int e_errw, input int e_idx);
        cur_mode = m; n_words = n; flip_addr = fa; fast_stop = fs;
        for (int i = 0; i < MAXW; i++) mem[i] = '0;
        do_reset();
        mode = 2'(m);
        run = 1'b1;
        for (int c = 0; c < 30000 && verify_starts < passes; c++) @(negedge clk);
        run = 1'b0;
        for (int c = 0; c < 5000 && busy; c++) @(negedge clk);
        #1;
        check("passes_reached", verify_starts, passes);
        check("busy_end", busy, 0);
        check("pass_counter_end", pass_counter, e_pass);
        check("fail_counter_end", fail_counter, e_fail);
        check("err_words_end", err_words, e_errw);
        check("model_pass_agrees", exp_pass, e_pass);
        check("model_fail_agrees", exp_fail, e_fail);
        check("model_errw_agrees", exp_errw, e_errw);
`ifdef MEM_TESTER_ERRLOG_EN
        if (e_idx >= 0) begin
            check("err_idx", err_idx, e_idx);
            check("err_got_xor_exp", err_got ^ err_exp, 1);
            check("err_exp", err_exp, m_first_exp);
        end
`endif
        $display("scenario mode=%0d words=%0d passes=%0d flip=%0d pass=%0d fail=%0d err_words=%0d (idx %0d)",
                 m, n, passes, fa, pass_counter, fail_counter, err_words, e_idx);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] walk_tab [20];
        int starts_seen, busy_seen;
        walk_tab = '{16'h0001, 16'h0002, 16'h0004, 16'h0008, 16'h0010, 16'h0020, 16'h0040,
                     16'h0080, 16'h0100, 16'h0200, 16'h0400, 16'h0800, 16'h1000, 16'h2000,
                     16'h4000, 16'h8000, 16'h0001, 16'h0002, 16'h0004, 16'h0008};

        // LFSR, 1024-word memory, three clean passes
        scenario(0, 1024, 3, -1, 0, 3, 0, 0, -1);
        check("lfsr_word0", wr_log[0], 16'hFFFF);
        check("lfsr_word1", wr_log[1], 16'hFFFE);
        check("lfsr_word3", wr_log[3], 16'hFFF8);

        // Walking one across 20 words
        scenario(2, 20, 1, -1, 0, 1, 0, 0, -1);
        for (int i = 0; i < 20; i++) check($sformatf("walk_word%0d", i), wr_log[i], walk_tab[i]);

        // Checkerboard with bit 0 of word 5 flipped
        scenario(3, 32, 1, 5, 0, 0, 1, 1, 5);
        check("chk_word0", wr_log[0], 16'h5555);
        check("chk_word1", wr_log[1], 16'hAAAA);

        // Inverted LFSR, error on the final word while stop rises with that ready
        scenario(1, 16, 2, 15, 1, 0, 2, 1, 15);
        check("inv_word0", wr_log[0], 16'h0000);
        check("inv_word1", wr_log[1], 16'h0001);

        // pass_counter saturation at 15
        scenario(0, 8, 17, -1, 0, 15, 0, 0, -1);

        // Every word bad: err_words saturates
        scenario(2, 20, 1, -2, 0, 0, 1, 15, 0);

        // Reset in the middle of the second pass's write sweep
        cur_mode = 0; n_words = 64; flip_addr = -1; fast_stop = 0;
        do_reset();
        mode = 2'd0;
        run = 1'b1;
        for (int c = 0; c < 5000 && !(verify_starts >= 1 && active && !sw_rnw && words_done >= 10); c++)
            @(negedge clk);
        check("midwrite_reached", (verify_starts >= 1 && active && !sw_rnw), 1);
        check("midwrite_pass_before", pass_counter, 1);
        #2 rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_busy", busy, 0);
        check("midrst_start", ctl_start, 0);
        check("midrst_rnw", ctl_rnw, 1);
        check("midrst_pass", pass_counter, 0);
        check("midrst_fail", fail_counter, 0);
        check("midrst_errw", err_words, 0);
        run = 1'b0;
        @(negedge clk); #2 rst_n = 1'b1;
        starts_seen = 0; busy_seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (ctl_start) starts_seen++;
            if (busy) busy_seen++;
        end
        check("idle_no_start", starts_seen, 0);
        check("idle_not_busy", busy_seen, 0);
        $display("scenario reset-mid-write pass=%0d fail=%0d busy=%0d", pass_counter, fail_counter, busy);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
